// File: rtl/prog_loader.sv
// Program loader: holds the core in reset, streams an image into instruction memory,
// releases the core after a settle delay and optionally watches the run length.
module prog_loader #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned ADDR_W      = $clog2(DEPTH),
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned RUN_LIMIT   = 0,
    parameter int unsigned RUN_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              overflow,
    output logic              timeout,
    output logic [ADDR_W:0]   word_count,
    output logic [RUN_W-1:0]  run_cycles
);

    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1) + 1;

    typedef enum logic [2:0] {StIdle, StLoad, StHold, StRun, StError} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                s_ready_q, s_ready_d;
    logic                imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic [DATA_W-1:0]   imem_wdata_q, imem_wdata_d;
    logic                core_rst_q, core_rst_d;
    logic                done_q, done_d;
    logic                overflow_q, overflow_d;
    logic                timeout_q, timeout_d;
    logic [CNT_W-1:0]    word_count_q, word_count_d;
    logic [RUN_W-1:0]    run_cycles_q, run_cycles_d;
    logic [RUN_W-1:0]    run_inc;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        hold_cnt_d   = hold_cnt_q;
        s_ready_d    = s_ready_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        core_rst_d   = core_rst_q;
        done_d       = done_q;
        overflow_d   = overflow_q;
        timeout_d    = timeout_q;
        word_count_d = word_count_q;
        run_cycles_d = run_cycles_q;
        run_inc      = (run_cycles_q == '1) ? run_cycles_q : run_cycles_q + RUN_W'(1);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d      = StLoad;
                    s_ready_d    = 1'b1;
                    ptr_d        = '0;
                    word_count_d = '0;
                end
            end
            StLoad: begin
                if (s_valid && s_ready_q) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = ptr_q;
                    imem_wdata_d = s_data;
                    ptr_d        = ptr_q + ADDR_W'(1);
                    word_count_d = word_count_q + CNT_W'(1);
                    if (s_last) begin
                        state_d    = StHold;
                        s_ready_d  = 1'b0;
                        hold_cnt_d = '0;
                    end else if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                        // Last slot filled but the image keeps going.
                        state_d    = StError;
                        s_ready_d  = 1'b0;
                        overflow_d = 1'b1;
                    end
                end
            end
            StHold: begin
                if (hold_cnt_q == HOLD_W'(HOLD_CYCLES)) begin
                    state_d      = StRun;
                    core_rst_d   = 1'b0;
                    done_d       = 1'b1;
                    run_cycles_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            StRun, StError: begin
                if (start) begin
                    state_d      = StLoad;
                    s_ready_d    = 1'b1;
                    ptr_d        = '0;
                    word_count_d = '0;
                    core_rst_d   = 1'b1;
                    done_d       = 1'b0;
                    run_cycles_d = '0;
                    overflow_d   = 1'b0;
                    timeout_d    = 1'b0;
                end else if (state_q == StRun) begin
                    run_cycles_d = run_inc;
                    if (RUN_LIMIT != 0 && run_inc == RUN_W'(RUN_LIMIT)) begin
                        state_d    = StError;
                        timeout_d  = 1'b1;
                        core_rst_d = 1'b1;
                        done_d     = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            hold_cnt_q   <= '0;
            s_ready_q    <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_rst_q   <= 1'b1;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            timeout_q    <= 1'b0;
            word_count_q <= '0;
            run_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            hold_cnt_q   <= hold_cnt_d;
            s_ready_q    <= s_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_rst_q   <= core_rst_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
            timeout_q    <= timeout_d;
            word_count_q <= word_count_d;
            run_cycles_q <= run_cycles_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_rst   = core_rst_q;
    assign done       = done_q;
    assign overflow   = overflow_q;
    assign timeout    = timeout_q;
    assign word_count = word_count_q;
    assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed vector table, corner-case sequences and random
// stimulus compared cycle by cycle against a timestamp-based reference model.
module tb_prog_loader;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int HOLD   = 4;
    localparam int LIMIT  = 100;
    localparam int RUN_W  = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              s_valid = 1'b0;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_last = 1'b0;
    logic              s_ready, imem_we, core_rst, done, overflow, timeout;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic [ADDR_W:0]   word_count;
    logic [RUN_W-1:0]  run_cycles;

    prog_loader #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .HOLD_CYCLES(HOLD),
        .RUN_LIMIT  (LIMIT),
        .RUN_W      (RUN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .core_rst  (core_rst),
        .done      (done),
        .overflow  (overflow),
        .timeout   (timeout),
        .word_count(word_count),
        .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: phase flags plus the edge index at which the core is released.
    bit          m_ready, m_hold, m_done, m_err, m_ovf, m_tmo, m_we;
    int          m_count, m_addr, m_release, m_run, edge_n;
    logic [31:0] m_wdata;
    int          wr_addrs[$];

    typedef struct {
        bit          r, st, v, l;
        logic [31:0] d;
        bit          e_crst, e_rdy, e_we;
        int          e_addr, e_wc;
        bit          e_done;
    } vec_t;

    vec_t vt[15];

    function automatic vec_t mk(bit r, bit st, bit v, bit l, logic [31:0] d, bit e_crst,
                                bit e_rdy, bit e_we, int e_addr, int e_wc, bit e_done);
        vec_t x;
        x.r = r; x.st = st; x.v = v; x.l = l; x.d = d;
        x.e_crst = e_crst; x.e_rdy = e_rdy; x.e_we = e_we;
        x.e_addr = e_addr; x.e_wc = e_wc; x.e_done = e_done;
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_n, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_ready = 0; m_hold = 0; m_done = 0; m_err = 0; m_ovf = 0; m_tmo = 0; m_we = 0;
        m_count = 0; m_addr = 0; m_wdata = '0; m_run = 0; m_release = 0;
    endfunction

    function automatic void model_edge(bit r, bit st, bit v, logic [31:0] d, bit l);
        int k = edge_n;
        if (r) begin
            model_reset();
            return;
        end
        m_we = 0;
        if (m_ready) begin
            if (v) begin
                m_we    = 1;
                m_addr  = m_count % DEPTH;
                m_wdata = d;
                m_count = m_count + 1;
                if (l) begin
                    m_ready   = 0;
                    m_hold    = 1;
                    m_release = k + HOLD + 1;
                end else if (m_count == DEPTH) begin
                    m_ready = 0;
                    m_ovf   = 1;
                    m_err   = 1;
                end
            end
        end else if (m_hold) begin
            if (k == m_release) begin
                m_hold = 0;
                m_done = 1;
                m_run  = 0;
            end
        end else if (m_done || m_err) begin
            if (st) begin
                m_ready = 1; m_count = 0; m_done = 0; m_err = 0;
                m_run = 0; m_ovf = 0; m_tmo = 0;
            end else if (m_done) begin
                m_run = k - m_release;
                if (m_run == LIMIT) begin
                    m_tmo  = 1;
                    m_err  = 1;
                    m_done = 0;
                end
            end
        end else if (st) begin
            m_ready = 1;
            m_count = 0;
        end
    endfunction

    task automatic step(input bit r, input bit st, input bit v, input logic [31:0] d,
                        input bit l);
        rst = r; start = st; s_valid = v; s_data = d; s_last = l;
        @(posedge clk);
        model_edge(r, st, v, d, l);
        #1;
        if (imem_we === 1'b1) wr_addrs.push_back(int'(imem_addr));
        chk("core_rst", core_rst, !m_done);
        chk("s_ready", s_ready, m_ready);
        chk("imem_we", imem_we, m_we);
        chk("imem_addr", imem_addr, m_addr);
        chk("imem_wdata", imem_wdata, m_wdata);
        chk("done", done, m_done);
        chk("overflow", overflow, m_ovf);
        chk("timeout", timeout, m_tmo);
        chk("word_count", word_count, m_count);
        chk("run_cycles", run_cycles, m_run);
        edge_n++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0);
    endtask

    initial begin
        model_reset();
        edge_n = 0;

        // Reset, start, 8-word image, then HOLD_CYCLES+1 edges to release.
        vt[0] = mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        vt[1] = mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            vt[2 + i] = mk(0, 0, 1, i == 7, 32'h13 + 32'(i), 1, i != 7, 1, i, i + 1, 0);
        for (int i = 0; i < 4; i++) vt[10 + i] = mk(0, 0, 0, 0, 0, 1, 0, 0, 7, 8, 0);
        vt[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 7, 8, 1);
        for (int i = 0; i < 15; i++) begin
            step(vt[i].r, vt[i].st, vt[i].v, vt[i].d, vt[i].l);
            chk("tbl_core_rst", core_rst, vt[i].e_crst);
            chk("tbl_s_ready", s_ready, vt[i].e_rdy);
            chk("tbl_imem_we", imem_we, vt[i].e_we);
            chk("tbl_imem_addr", imem_addr, vt[i].e_addr);
            chk("tbl_word_count", word_count, vt[i].e_wc);
            chk("tbl_done", done, vt[i].e_done);
        end

        // Gapped valid during a 4-word reload from RUN.
        wr_addrs.delete();
        step(0, 1, 0, '0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, i % 2 == 1, 32'hA0 + 32'(i), i == 7);
        chk("gap_writes", wr_addrs.size(), 4);
        for (int i = 0; i < wr_addrs.size(); i++) chk("gap_addr", wr_addrs[i], i);
        idle(HOLD + 1);
        chk("gap_done", done, 1);

        // Watchdog expiry, then reload clears it.
        idle(LIMIT + 2);
        chk("wd_timeout", timeout, 1);
        chk("wd_core_rst", core_rst, 1);
        chk("wd_run_cycles", run_cycles, LIMIT);
        step(0, 1, 0, '0, 0);
        step(0, 0, 1, 32'h55, 0);
        step(0, 0, 1, 32'h66, 1);
        idle(HOLD + 1);
        chk("reload_timeout", timeout, 0);
        chk("reload_done", done, 1);

        // Overflow: 17 words, no last.
        wr_addrs.delete();
        step(0, 1, 0, '0, 0);
        for (int i = 0; i < 17; i++) step(0, 0, 1, 32'h1000 + 32'(i), 0);
        chk("ovf_writes", wr_addrs.size(), DEPTH);
        chk("ovf_flag", overflow, 1);
        chk("ovf_s_ready", s_ready, 0);
        chk("ovf_core_rst", core_rst, 1);

        // Reset in the middle of a load.
        step(0, 1, 0, '0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h2000 + 32'(i), 0);
        step(1, 0, 1, 32'h2003, 0);
        chk("mid_rst_core_rst", core_rst, 1);
        chk("mid_rst_s_ready", s_ready, 0);
        chk("mid_rst_we", imem_we, 0);
        chk("mid_rst_addr", imem_addr, 0);
        chk("mid_rst_wc", word_count, 0);
        step(0, 1, 0, '0, 0);
        step(0, 0, 1, 32'h3000, 0);
        chk("restart_addr", imem_addr, 0);
        chk("restart_we", imem_we, 1);

        // Full DEPTH image terminated on its last word.
        step(1, 0, 0, '0, 0);
        step(0, 1, 0, '0, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 32'h4000 + 32'(i), i == DEPTH - 1);
        idle(HOLD + 1);
        chk("full_overflow", overflow, 0);
        chk("full_done", done, 1);
        chk("full_wc", word_count, DEPTH);

        // Random traffic: frequent restarts, then sparse ones so the watchdog can fire.
        for (int i = 0; i < 3000; i++) begin
            bit r, st, v, l;
            r  = ($urandom_range(0, 199) == 0);
            st = (i < 1500) ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 299) == 0);
            v  = ($urandom_range(0, 2) != 0);
            l  = ($urandom_range(0, 9) == 0);
            step(r, st, v, $urandom, l);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
